// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector with a registered match pulse
// and a saturating, sticky-flagged hit counter. Resets to the legacy "010" overlap detector.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 10,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] users_count,
    output logic             cnt_sat
);

    localparam logic [1:0]       S_HUNT  = 2'd0;
    localparam logic [1:0]       S_MATCH = 2'd1;
    localparam logic [1:0]       S_FLUSH = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W:0]   LEN_INC = (LEN_W + 1)'(1);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b010);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Configuration
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;

    // Detector state
    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_y;

    // Counter
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic [LEN_W-1:0] w_cfg_len;
    logic [PAT_W-1:0] w_hist_shift;
    logic [PAT_W-1:0] w_mask;
    logic             w_fill_ok;
    logic             w_pat_eq;
    logic             w_accept;
    logic             w_hit;
    logic [LEN_W-1:0] w_fill_inc;

    logic [1:0]       w_state_nx;
    logic [LEN_W-1:0] w_fill_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_sat_nx;

    // Out-of-range lengths clamp into 1..PAT_W so the mask below is always valid.
    assign w_cfg_len    = (cfg_len == '0)     ? LEN_ONE :
                          (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    assign w_hist_shift = {r_hist[PAT_W-2:0], x};
    assign w_mask       = {PAT_W{1'b1}} >> (LEN_MAX - r_len);
    assign w_fill_ok    = ({1'b0, r_fill} + LEN_INC) >= {1'b0, r_len};
    assign w_pat_eq     = ((w_hist_shift ^ r_pat) & w_mask) == '0;
    assign w_accept     = x_valid & ~cfg_load;

    // A bit taken in the flush cycle only starts the new history; it never completes a match.
    assign w_hit        = w_accept & (r_state != S_FLUSH) & w_fill_ok & w_pat_eq;
    assign w_fill_inc   = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_ONE;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx = S_HUNT;
        w_fill_nx  = r_fill;
        if (cfg_load) begin
            w_state_nx = S_FLUSH;
            w_fill_nx  = '0;
        end else if (x_valid) begin
            if (w_hit) begin
                w_state_nx = S_MATCH;
                w_fill_nx  = r_ovl ? w_fill_inc : '0;
            end else begin
                w_state_nx = S_HUNT;
                w_fill_nx  = w_fill_inc;
            end
        end
    end

    always_comb begin
        w_cnt_nx = r_cnt;
        w_sat_nx = r_sat;
        if (cnt_clr) begin
            w_cnt_nx = '0;
            w_sat_nx = 1'b0;
        end else if (w_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_nx = r_cnt + CNT_ONE;
            if ((r_cnt + CNT_ONE) == CNT_MAX) begin
                w_sat_nx = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= PAT_RST;
            r_len <= LEN_RST;
            r_ovl <= 1'b1;
        end else if (cfg_load) begin
            r_pat <= cfg_pattern;
            r_len <= w_cfg_len;
            r_ovl <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
            r_hist  <= '0;
            r_fill  <= '0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fill  <= w_fill_nx;
            r_y     <= (w_state_nx == S_MATCH);
            if (w_accept) begin
                r_hist <= w_hist_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_sat <= w_sat_nx;
        end
    end

    assign y           = r_y;
    assign users_count = r_cnt;
    assign cnt_sat     = r_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios then random traffic, each cycle
// compared against a queue-based model of the matching rules.
module tb_seq_detect_param;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(PAT_W) + 1;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             y;
    logic [CNT_W-1:0] users_count;
    logic             cnt_sat;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: accepted bits since the last flush / non-overlap match.
    int               m_q[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_flush;
    bit               m_y;
    int               m_cnt;
    bit               m_sat;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .y          (y),
        .users_count(users_count),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pat   = 8'b0000_0010;
        m_len   = 3;
        m_ovl   = 1'b1;
        m_flush = 1'b0;
        m_y     = 1'b0;
        m_cnt   = 0;
        m_sat   = 1'b0;
    endtask

    // Last m_len accepted bits, newest first, against pattern bits [0], [1], ...
    function automatic bit tail_match();
        if (m_q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_q[m_q.size() - 1 - i] != int'(m_pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cfg_load) begin
            m_pat   = cfg_pattern;
            m_len   = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
            m_ovl   = cfg_overlap;
            m_flush = 1'b1;
            m_q.delete();
        end else begin
            if (x_valid) begin
                m_q.push_back(int'(x));
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                hit = !m_flush && tail_match();
                if (hit && !m_ovl) m_q.delete();
            end
            m_flush = 1'b0;
        end
        m_y = hit;
        if (cnt_clr) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (hit && m_cnt < CNT_TOP) begin
            m_cnt++;
            if (m_cnt == CNT_TOP) m_sat = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("y", 32'(y), 32'(m_y));
        check("users_count", 32'(users_count), 32'(m_cnt));
        check("cnt_sat", 32'(cnt_sat), 32'(m_sat));
        if (y === 1'b1) pulses++;
    endtask

    task automatic send(input logic b);
        x_valid = 1'b1;
        x       = b;
        cycle();
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cycle();
        cfg_load = 1'b0;
        check("y_after_load", 32'(y), 32'(0));
        cycle();
    endtask

    task automatic clear_count();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check("rst_y", 32'(y), 32'(0));
        check("rst_count", 32'(users_count), 32'(0));
        check("rst_sat", 32'(cnt_sat), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Legacy default 010 overlapping
        pulses = 0;
        send_bits(16'b01010, 5);
        check("legacy_pulses", 32'(pulses), 32'(2));
        check("legacy_count", 32'(users_count), 32'(2));

        // Non-overlap then overlap with 0101
        clear_count();
        load(8'b0101, 4'd4, 1'b0);
        pulses = 0;
        send_bits(16'b01010101, 8);
        check("novl_pulses", 32'(pulses), 32'(2));
        check("novl_count", 32'(users_count), 32'(2));
        clear_count();
        load(8'b0101, 4'd4, 1'b1);
        pulses = 0;
        send_bits(16'b01010101, 8);
        check("ovl_pulses", 32'(pulses), 32'(3));
        check("ovl_count", 32'(users_count), 32'(3));

        // Valid gaps stretch the sequence
        clear_count();
        load(8'b010, 4'd3, 1'b1);
        pulses = 0;
        send(1'b0);
        idle(3);
        send(1'b1);
        idle(3);
        send(1'b0);
        check("gap_pulse_now", 32'(y), 32'(1));
        idle(2);
        check("gap_pulses", 32'(pulses), 32'(1));

        // cfg_len=0 clamps to 1; 17 matches saturate the 4-bit counter
        clear_count();
        load(8'b1, 4'd0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 17; i++) send(1'b1);
        check("sat_pulses", 32'(pulses), 32'(17));
        check("sat_count", 32'(users_count), 32'(CNT_TOP));
        check("sat_flag", 32'(cnt_sat), 32'(1));
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        check("clr_y", 32'(y), 32'(1));
        check("clr_count", 32'(users_count), 32'(0));
        check("clr_sat", 32'(cnt_sat), 32'(0));

        // A bit accepted during the flush cycle cannot match
        cfg_load = 1'b1;
        cfg_pattern = 8'b1;
        cfg_len = 4'd1;
        cfg_overlap = 1'b1;
        cycle();
        cfg_load = 1'b0;
        pulses = 0;
        send(1'b1);
        send(1'b1);
        check("flush_bit_pulses", 32'(pulses), 32'(1));

        // cfg_len=12 behaves as 8
        clear_count();
        load(8'b10110011, 4'd12, 1'b1);
        pulses = 0;
        send_bits(16'b10110011, 8);
        check("clamp8_pulses", 32'(pulses), 32'(1));

        // Bit presented with cfg_load is discarded, partial match lost
        load(8'b010, 4'd3, 1'b1);
        clear_count();
        pulses = 0;
        send(1'b0);
        send(1'b1);
        cfg_load = 1'b1;
        x_valid  = 1'b1;
        x        = 1'b0;
        cycle();
        cfg_load = 1'b0;
        x_valid  = 1'b0;
        idle(1);
        send(1'b0);
        check("discard_pulses", 32'(pulses), 32'(0));
        check("discard_count", 32'(users_count), 32'(0));

        // Reset mid-stream restores 010/3/overlap
        load(8'b0110, 4'd4, 1'b1);
        send_bits(16'b0110, 4);
        send_bits(16'b011, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_y", 32'(y), 32'(0));
        check("midrst_count", 32'(users_count), 32'(0));
        check("midrst_sat", 32'(cnt_sat), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        send(1'b0);
        check("midrst_nopulse", 32'(pulses), 32'(0));
        send(1'b1);
        send(1'b0);
        check("midrst_default", 32'(pulses), 32'(1));

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            x_valid  = ($urandom_range(0, 3) != 0);
            x        = 1'($urandom_range(0, 1));
            cnt_clr  = ($urandom_range(0, 99) == 0);
            cfg_load = ($urandom_range(0, 47) == 0);
            if (cfg_load) begin
                cfg_pattern = PAT_W'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                          : LEN_W'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        x_valid  = 1'b0;
        cnt_clr  = 1'b0;
        cfg_load = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
